bram_multi_reader: RTL and testbench
====================================

// Module: bram_multi_reader
// PURPOSE
//   Parametrised BRAM server: one write method plus NCH independent read channels sharing one synchronous read port.
//   Each channel holds one outstanding read; the result stays in a per-channel register until the client consumes it (deq).
//   Successor to the single-client BRAM interface: adds byte enables, multiple readers and round-robin arbitration.
//   Sits between several client modules and a single inferred dual-port (1W/1R) memory array.
// PARAMETERS
//   DEPTH  1024  number of words; power of two, >=2; AW = $clog2(DEPTH)
//   WIDTH  48    word width in bits; multiple of 8; BW = WIDTH/8 byte lanes
//   NCH    4     read channels, 1..16; CW = max(1,$clog2(NCH))
// PORTS
//   CLK            in   1         clock; all state updates on rising edge
//   nRST           in   1         reset, asynchronous, active-low
//   write__ENA     in   1         write request; taken when write__RDY=1
//   write$addr     in   AW        write word address
//   write$data     in   WIDTH     write data
//   write$be       in   BW        byte-lane enables; bit i covers data[8i+7:8i]
//   write__RDY     out  1         write ready; always 1 out of reset
//   read__ENA      in   NCH       per-channel read request
//   read$addr      in   NCH*AW    per-channel address, channel c at [c*AW +: AW]
//   read__RDY      out  NCH       channel c can accept read__ENA[c]
//   dataOut        out  NCH*WIDTH per-channel result, channel c at [c*WIDTH +: WIDTH]
//   dataOut__RDY   out  NCH       dataOut[c] valid
//   deq__ENA       in   NCH       consume dataOut[c]; legal only when dataOut__RDY[c]=1
//   deq__RDY       out  NCH       equals dataOut__RDY
// BEHAVIOUR
//   Reset (nRST low, async): all channels IDLE, rr_last=NCH-1, dataOut=0, dataOut__RDY=0, read__RDY=all 1,
//     write__RDY=0 while nRST low, 1 thereafter. Memory contents are not reset; reset mid-operation drops pending/issued reads.
//   Write: write__ENA & write__RDY -> lanes with be=1 updated at that edge; be=0 write is a no-op. Never blocked by reads.
//   Per-channel FSM (state enum in package):
//     IDLE  : read__RDY=1; read__ENA -> latch addr, go PEND.
//     PEND  : wait for grant; granted -> address to memory, go ISSUED.
//     ISSUED: memory output valid this cycle -> capture into dataOut[c], go VALID.
//     VALID : dataOut__RDY=1; deq__ENA -> IDLE. No new read accepted until deq (read__RDY=0 in PEND/ISSUED/VALID).
//   read__ENA[c] while read__RDY[c]=0: ignored (assertion error in sim).
//   Arbitration: one grant per cycle among PEND channels, round-robin starting at rr_last+1 mod NCH; rr_last updates to the
//     granted channel. Zero PEND channels -> no grant, rr_last unchanged.
//   Latency: read__ENA in cycle t -> dataOut__RDY in cycle t+3 uncontended; worst case t+2+NCH.
//   Read-during-write: granted read and write to same address in same cycle -> see CONFIGURATION.
//   Address arithmetic: addresses used unmodified (DEPTH power of two, no wrap logic); RR pointer wraps NCH-1 -> 0.
//   Simultaneous deq__ENA[c] and read__ENA[c] in same cycle: deq honoured, read ignored (channel not IDLE that cycle).
// CONFIGURATION
//   BRAM_BYPASS_EN defined: same-cycle same-address write forwards to the read: result = new data on be=1 lanes, old data on others.
//   BRAM_BYPASS_EN undefined: read returns pre-write (old) data on all lanes; no forwarding logic generated.
// STRUCTURE
//   Package bram_pkg: typedef enum logic[1:0] {BR_IDLE,BR_PEND,BR_ISSUED,BR_VALID} bram_ch_state_t; helper function be_merge().
//   Sub-module bram_rr_arbiter #(N): inputs req[N], last[CW]; outputs grant_valid, grant_idx[CW]; purely combinational.
//   Top holds memory array, registered read data, per-channel FSM/address/data registers, rr_last register.
// TESTING
//   1 Reset then write addr 5 = 48'h0123_4567_89AB be=all 1; ch0 read 5 at t -> dataOut[0]=48'h0123_4567_89AB, dataOut__RDY[0] at t+3.
//   2 All 4 channels read addr 0..3 in same cycle -> grants in order ch0,ch1,ch2,ch3; RDYs at t+3..t+6; rr_last=3 after.
//   3 Word 7 = 48'hFFFF_FFFF_FFFF; write 7 data 0 be=6'b000011 -> read 7 returns 48'hFFFF_FFFF_0000.
//   4 Write addr 9 data 48'hA5 (old 48'h0) in grant cycle of ch1 read 9 -> 48'hA5 with BRAM_BYPASS_EN, 48'h0 without.
//   5 ch2 VALID, no deq for 20 cycles -> dataOut[2] stable, read__RDY[2]=0; then deq + read__ENA same cycle -> read ignored, IDLE next.
//   6 Assert nRST low mid-ISSUED on ch0/ch1 -> dataOut__RDY=0 and read__RDY=all 1 immediately (async); memory word 5 still readable.

Source files
------------

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// bram_pkg: shared types and helpers for the multi-reader BRAM server.
// Rev 1.0
// ============================================================================
package bram_pkg;

  typedef enum logic [1:0] {
    BR_IDLE   = 2'd0,
    BR_PEND   = 2'd1,
    BR_ISSUED = 2'd2,
    BR_VALID  = 2'd3
  } bram_ch_state_t;

  // One byte lane: enabled lanes take the new byte, others keep the old one.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// bram_rr_arbiter: combinational round-robin grant, search starts at last+1.
// Rev 1.0
// ============================================================================
module bram_rr_arbiter #(
  parameter int N = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic          grant_valid,
  output logic [CW-1:0] grant_idx
);

  // Outer loop walks priority order, so the first hit is the round-robin winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!grant_valid && req[j] && (j == ((int'(last) + i) % N))) begin
          grant_valid = 1'b1;
          grant_idx   = CW'(j);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_multi_reader.sv
`default_nettype none
// ============================================================================
// bram_multi_reader: NCH one-outstanding read channels plus a byte-enabled write
// sharing one 1W/1R BRAM. Optional macro BRAM_BYPASS_EN forwards same-cycle writes.
// Rev 1.0
// ============================================================================
module bram_multi_reader
  import bram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 48,
  parameter int NCH   = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 write__ENA,
  input  logic [AW-1:0]        write__addr,
  input  logic [WIDTH-1:0]     write__data,
  input  logic [BW-1:0]        write__be,
  output logic                 write__RDY,
  input  logic [NCH-1:0]       read__ENA,
  input  logic [NCH*AW-1:0]    read__addr,
  output logic [NCH-1:0]       read__RDY,
  output logic [NCH*WIDTH-1:0] dataOut,
  output logic [NCH-1:0]       dataOut__RDY,
  input  logic [NCH-1:0]       deq__ENA,
  output logic [NCH-1:0]       deq__RDY
);

  logic             write_rdy_q;
  logic             wr_fire;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_q;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    ch_addr [NCH];
  logic [NCH-1:0]   pend_vec;
  logic [CW-1:0]    rr_last;
  logic [CW-1:0]    grant_idx;
  logic             grant_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) write_rdy_q <= 1'b0;
    else       write_rdy_q <= 1'b1;
  end

  assign write__RDY = write_rdy_q;
  assign wr_fire    = write__ENA & write_rdy_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)            rr_last <= CW'(NCH - 1);
    else if (grant_valid) rr_last <= grant_idx;
  end

  bram_rr_arbiter #(.N(NCH)) u_arb (
    .req         (pend_vec),
    .last        (rr_last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign rd_addr = ch_addr[grant_idx];

`ifdef BRAM_BYPASS_EN
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_fire && (write__addr == rd_addr)) begin
      for (int b = 0; b < BW; b++)
        rd_word[8*b +: 8] = be_merge(rd_word[8*b +: 8], write__data[8*b +: 8], write__be[b]);
    end
  end
`else
  assign rd_word = mem[rd_addr];
`endif

  // Memory array and its registered read port are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      for (int b = 0; b < BW; b++)
        if (write__be[b]) mem[write__addr][8*b +: 8] <= write__data[8*b +: 8];
    end
    if (grant_valid) rd_q <= rd_word;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    bram_ch_state_t   state;
    bram_ch_state_t   state_nxt;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        state  <= BR_IDLE;
        addr_q <= '0;
        data_q <= '0;
      end else begin
        state <= state_nxt;
        if (state == BR_IDLE && read__ENA[c]) addr_q <= read__addr[c*AW +: AW];
        if (state == BR_ISSUED)               data_q <= rd_q;
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        BR_IDLE:   if (read__ENA[c]) state_nxt = BR_PEND;
        BR_PEND:   if (grant_valid && grant_idx == CW'(c)) state_nxt = BR_ISSUED;
        BR_ISSUED: state_nxt = BR_VALID;
        BR_VALID:  if (deq__ENA[c]) state_nxt = BR_IDLE;
        default:   state_nxt = BR_IDLE;
      endcase
    end

    assign pend_vec[c]                = (state == BR_PEND);
    assign ch_addr[c]                 = addr_q;
    assign read__RDY[c]               = (state == BR_IDLE);
    assign dataOut__RDY[c]            = (state == BR_VALID);
    assign deq__RDY[c]                = (state == BR_VALID);
    assign dataOut[c*WIDTH +: WIDTH]  = data_q;

    // A read alongside deq is a defined no-op; a read on a busy channel alone is misuse.
    a_read_when_busy: assert property (@(posedge CLK) disable iff (!nRST)
      !(read__ENA[c] && (state != BR_IDLE) && !deq__ENA[c]));
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_multi_reader.sv
`default_nettype none
// ============================================================================
// tb_bram_multi_reader: directed cases plus random traffic against a transaction model.
// Rev 1.0
// ============================================================================
module tb_bram_multi_reader;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 48;
  localparam int NCH   = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = WIDTH / 8;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b0;
  logic                 write__ENA = 1'b0;
  logic [AW-1:0]        write__addr = '0;
  logic [WIDTH-1:0]     write__data = '0;
  logic [BW-1:0]        write__be = '0;
  logic                 write__RDY;
  logic [NCH-1:0]       read__ENA = '0;
  logic [NCH*AW-1:0]    read__addr = '0;
  logic [NCH-1:0]       read__RDY;
  logic [NCH*WIDTH-1:0] dataOut;
  logic [NCH-1:0]       dataOut__RDY;
  logic [NCH-1:0]       deq__ENA = '0;
  logic [NCH-1:0]       deq__RDY;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  always #5 CLK = ~CLK;

  bram_multi_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NCH(NCH)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .write__ENA   (write__ENA),
    .write__addr  (write__addr),
    .write__data  (write__data),
    .write__be    (write__be),
    .write__RDY   (write__RDY),
    .read__ENA    (read__ENA),
    .read__addr   (read__addr),
    .read__RDY    (read__RDY),
    .dataOut      (dataOut),
    .dataOut__RDY (dataOut__RDY),
    .deq__ENA     (deq__ENA),
    .deq__RDY     (deq__RDY)
  );

  // Transaction-level model: a channel is free, waiting for arbitration, in flight, or holding data.
  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [NCH];
  bit               m_pend [NCH];
  bit               m_fly  [NCH];
  bit               m_valid[NCH];
  logic [AW-1:0]    m_addr [NCH];
  logic [WIDTH-1:0] m_q    [NCH];
  logic [WIDTH-1:0] m_data [NCH];
  int               m_last;
  bit               m_wrdy;

  task automatic model_step();
    int g;
    logic [WIDTH-1:0] word;
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      int cc;
      cc = (m_last + k) % NCH;
      if (g < 0 && m_pend[cc]) g = cc;
    end
    for (int c = 0; c < NCH; c++) begin
      if (!m_busy[c]) begin
        if (read__ENA[c]) begin
          m_busy[c] = 1'b1;
          m_pend[c] = 1'b1;
          m_addr[c] = read__addr[c*AW +: AW];
        end
      end else if (m_valid[c] && deq__ENA[c]) begin
        m_valid[c] = 1'b0;
        m_busy[c]  = 1'b0;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (m_fly[c]) begin
        m_fly[c]   = 1'b0;
        m_valid[c] = 1'b1;
        m_data[c]  = m_q[c];
      end
    end
    if (g >= 0) begin
      word = m_mem[m_addr[g]];
`ifdef BRAM_BYPASS_EN
      if (write__ENA && m_wrdy && write__addr == m_addr[g])
        for (int b = 0; b < BW; b++)
          if (write__be[b]) word[8*b +: 8] = write__data[8*b +: 8];
`endif
      m_q[g]    = word;
      m_fly[g]  = 1'b1;
      m_pend[g] = 1'b0;
      m_last    = g;
    end
    if (write__ENA && m_wrdy)
      for (int b = 0; b < BW; b++)
        if (write__be[b]) m_mem[write__addr][8*b +: 8] = write__data[8*b +: 8];
    m_wrdy = 1'b1;
  endtask

  initial forever begin
    @(posedge CLK or negedge nRST);
    if (!nRST) begin
      for (int c = 0; c < NCH; c++) begin
        m_busy[c] = 1'b0; m_pend[c] = 1'b0; m_fly[c] = 1'b0; m_valid[c] = 1'b0;
        m_data[c] = '0;
      end
      m_last = NCH - 1;
      m_wrdy = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("write_rdy", 64'(write__RDY), 64'(m_wrdy));
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("read_rdy%0d", c), 64'(read__RDY[c]), 64'(!m_busy[c]));
        chk($sformatf("dout_rdy%0d", c), 64'(dataOut__RDY[c]), 64'(m_valid[c]));
        chk($sformatf("deq_rdy%0d", c), 64'(deq__RDY[c]), 64'(m_valid[c]));
        chk($sformatf("dout%0d", c), 64'(dataOut[c*WIDTH +: WIDTH]), 64'(m_data[c]));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
    write__ENA = 1'b0;
    read__ENA  = '0;
    deq__ENA   = '0;
  endtask

  task automatic do_write(input int a, input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
    write__ENA  = 1'b1;
    write__addr = AW'(a);
    write__data = d;
    write__be   = be;
    cyc();
  endtask

  task automatic start_read(input int c, input int a);
    read__ENA[c]             = 1'b1;
    read__addr[c*AW +: AW]   = AW'(a);
  endtask

  task automatic read_check(input int c, input int a, input logic [WIDTH-1:0] exp, input string nm);
    start_read(c, a);
    cyc(); cyc();
    @(negedge CLK);
    chk({nm, "_early"}, 64'(dataOut__RDY[c]), 64'd0);
    cyc();
    @(negedge CLK);
    chk({nm, "_rdy"}, 64'(dataOut__RDY[c]), 64'd1);
    chk({nm, "_data"}, 64'(dataOut[c*WIDTH +: WIDTH]), 64'(exp));
    deq__ENA[c] = 1'b1;
    cyc();
  endtask

  logic [3:0]  t2_exp [6] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
  logic [63:0] r;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_write_rdy", 64'(write__RDY), 64'd0);
    chk("rst_read_rdy", 64'(read__RDY), 64'hF);
    chk("rst_dout_rdy", 64'(dataOut__RDY), 64'h0);
    chk("rst_dout0", 64'(dataOut[0 +: WIDTH]), 64'h0);
    chk_en = 1'b1;
    nRST   = 1'b1;
    cyc();
    @(negedge CLK);
    chk("write_rdy_up", 64'(write__RDY), 64'd1);

    for (int a = 0; a < DEPTH; a++) do_write(a, '0, '1);

    // Single uncontended read
    do_write(5, 48'h0123_4567_89AB, '1);
    read_check(0, 5, 48'h0123_4567_89AB, "t1");
    read_check(3, 5, 48'h0123_4567_89AB, "prime_rr");

    // Four simultaneous readers, round-robin from ch0
    for (int c = 0; c < NCH; c++) do_write(c, 48'h1000 + 48'(c), '1);
    for (int c = 0; c < NCH; c++) start_read(c, c);
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge CLK);
      chk($sformatf("t2_rdy_k%0d", k + 1), 64'(dataOut__RDY), 64'(t2_exp[k]));
    end
    for (int c = 0; c < NCH; c++)
      chk($sformatf("t2_data%0d", c), 64'(dataOut[c*WIDTH +: WIDTH]), 64'h1000 + 64'(c));
    deq__ENA = '1;
    cyc();

    // Partial byte-enable write
    do_write(7, 48'hFFFF_FFFF_FFFF, '1);
    do_write(7, 48'h0, 6'b000011);
    read_check(0, 7, 48'hFFFF_FFFF_0000, "t3");

    // Write landing in the grant cycle of a read to the same word
    start_read(1, 9);
    cyc();
    write__ENA = 1'b1; write__addr = AW'(9); write__data = 48'hA5; write__be = '1;
    cyc(); cyc();
    @(negedge CLK);
    chk("t4_rdy", 64'(dataOut__RDY[1]), 64'd1);
`ifdef BRAM_BYPASS_EN
    chk("t4_data", 64'(dataOut[1*WIDTH +: WIDTH]), 64'hA5);
`else
    chk("t4_data", 64'(dataOut[1*WIDTH +: WIDTH]), 64'h0);
`endif
    deq__ENA[1] = 1'b1;
    cyc();
    read_check(1, 9, 48'hA5, "t4_after");

    // Held result, then deq with a simultaneous read
    start_read(2, 7);
    cyc(); cyc(); cyc();
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk("t5_hold_data", 64'(dataOut[2*WIDTH +: WIDTH]), 64'hFFFF_FFFF_0000);
      chk("t5_hold_rdy", 64'(read__RDY[2]), 64'd0);
      cyc();
    end
    deq__ENA[2] = 1'b1;
    start_read(2, 5);
    cyc();
    @(negedge CLK);
    chk("t5_idle", 64'(read__RDY[2]), 64'd1);
    cyc(); cyc(); cyc();
    @(negedge CLK);
    chk("t5_read_ignored", 64'(dataOut__RDY[2]), 64'd0);

    // Asynchronous reset with reads in flight
    start_read(0, 5);
    start_read(1, 5);
    cyc(); cyc();
    #2 nRST = 1'b0;
    #1;
    chk("t6_read_rdy", 64'(read__RDY), 64'hF);
    chk("t6_dout_rdy", 64'(dataOut__RDY), 64'h0);
    chk("t6_write_rdy", 64'(write__RDY), 64'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    cyc();
    read_check(3, 5, 48'h0123_4567_89AB, "t6_mem");

    // Random traffic over a small address window to force collisions
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        r           = {$urandom(), $urandom()};
        write__ENA  = 1'b1;
        write__addr = AW'($urandom_range(0, 15));
        write__data = r[WIDTH-1:0];
        write__be   = BW'($urandom());
      end
      for (int c = 0; c < NCH; c++) begin
        if (!m_busy[c]) begin
          if ($urandom_range(0, 1) == 1) start_read(c, $urandom_range(0, 15));
        end else if (m_valid[c] && $urandom_range(0, 2) != 0) begin
          deq__ENA[c] = 1'b1;
          if ($urandom_range(0, 3) == 0) start_read(c, $urandom_range(0, 15));
        end
      end
      cyc();
    end

    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NCH; c++) if (m_valid[c]) deq__ENA[c] = 1'b1;
      cyc();
    end
    @(negedge CLK);
    chk("drain_idle", 64'(read__RDY), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
